// File: rtl/trade_pkg.sv
// Shared definitions for the UDP trade-report path: trade word field positions
// and the transmit FSM state encoding.
package trade_pkg;

  localparam int PRICE_MSB = 31;
  localparam int PRICE_LSB = 16;
  localparam int BUY_BIT   = 15;
  localparam int BOT_BIT   = 14;
  localparam int QTY_MSB   = 13;
  localparam int QTY_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEQ  = 3'd2,
    S_PAY  = 3'd3,
    S_GAP  = 3'd4
  } tx_state_e;

  // Packs the trade fields into the 32-bit trade_info word.
  function automatic logic [31:0] trade_word(input logic [15:0] price, input logic buy,
                                             input logic bot, input logic [13:0] qty);
    logic [31:0] w;
    w = 32'd0;
    w[PRICE_MSB:PRICE_LSB] = price;
    w[BUY_BIT]             = buy;
    w[BOT_BIT]             = bot;
    w[QTY_MSB:QTY_LSB]     = qty;
    return w;
  endfunction

endpackage

// File: rtl/trade_report_tx.sv
// Serializes one 32-bit trade report per packet onto an AXI-Stream byte bus:
// header fill bytes, 16-bit sequence number, 4-byte payload, all big-endian.
module trade_report_tx
  import trade_pkg::*;
#(
  parameter int         HDR_LEN  = 42,
  parameter logic [7:0] HDR_FILL = 8'hAA,
  parameter int         IFG      = 2
) (
  input  logic        clk_udp,
  input  logic        rst_udp,
  input  logic [31:0] trade_in,
  input  logic        trade_in_valid,
  output logic        trade_in_ready,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic        tx_axis_tlast,
  output logic [15:0] tx_seq,
  output logic        tx_busy
);

  localparam logic [7:0] HDR_LAST = (HDR_LEN > 0) ? 8'(HDR_LEN - 1) : 8'd0;
  localparam logic [7:0] IFG_LAST = (IFG > 0) ? 8'(IFG - 1) : 8'd0;

  tx_state_e   r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [15:0] r_seq, w_seq_nxt;
  logic [15:0] r_tx_seq, w_tx_seq_nxt;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_ready;
  logic        w_adv;
  logic [7:0]  w_byte;
  logic        w_valid_nxt;
  logic        w_last_nxt;

  assign w_adv = r_tvalid & tx_axis_tready;

  // Next-state logic: state/counter always name the byte presented in the following cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_word_nxt   = r_word;
    w_seq_nxt    = r_seq;
    w_tx_seq_nxt = r_tx_seq;
    case (r_state)
      S_IDLE: begin
        if (trade_in_valid && r_ready) begin
          w_word_nxt  = trade_in;
          w_seq_nxt   = r_tx_seq;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = (HDR_LEN == 0) ? S_SEQ : S_HDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        if (w_adv && (r_cnt == HDR_LAST)) begin
          w_state_nxt = S_SEQ;
          w_cnt_nxt   = 8'd0;
        end else if (w_adv) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_SEQ: begin
        if (w_adv && (r_cnt == 8'd1)) begin
          w_state_nxt = S_PAY;
          w_cnt_nxt   = 8'd0;
        end else if (w_adv) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_PAY: begin
        if (w_adv && (r_cnt == 8'd3)) begin
          w_tx_seq_nxt = r_tx_seq + 16'd1;
          w_state_nxt  = (IFG == 0) ? S_IDLE : S_GAP;
          w_cnt_nxt    = 8'd0;
        end else if (w_adv) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_GAP: begin
        if (r_cnt == IFG_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Byte mux driven from the next state so the output flops carry the byte without a bubble.
  always_comb begin
    w_byte      = 8'h00;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    case (w_state_nxt)
      S_HDR: begin
        w_byte      = HDR_FILL;
        w_valid_nxt = 1'b1;
      end
      S_SEQ: begin
        w_byte      = w_cnt_nxt[0] ? w_seq_nxt[7:0] : w_seq_nxt[15:8];
        w_valid_nxt = 1'b1;
      end
      S_PAY: begin
        w_valid_nxt = 1'b1;
        w_last_nxt  = (w_cnt_nxt == 8'd3);
        case (w_cnt_nxt[1:0])
          2'd0:    w_byte = w_word_nxt[31:24];
          2'd1:    w_byte = w_word_nxt[23:16];
          2'd2:    w_byte = w_word_nxt[15:8];
          default: w_byte = w_word_nxt[7:0];
        endcase
      end
      default: begin
        w_byte      = 8'h00;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // State, holding register, sequence counter and registered AXI-Stream outputs.
  always_ff @(posedge clk_udp or posedge rst_udp) begin
    if (rst_udp) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_word   <= 32'd0;
      r_seq    <= 16'd0;
      r_tx_seq <= 16'd0;
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_word   <= w_word_nxt;
      r_seq    <= w_seq_nxt;
      r_tx_seq <= w_tx_seq_nxt;
      r_tdata  <= w_byte;
      r_tvalid <= w_valid_nxt;
      r_tlast  <= w_last_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
    end
  end

  assign trade_in_ready = r_ready;
  assign tx_axis_tdata  = r_tdata;
  assign tx_axis_tvalid = r_tvalid;
  assign tx_axis_tlast  = r_tlast;
  assign tx_seq         = r_tx_seq;
  assign tx_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_trade_report_tx.sv
// Directed bench for trade_report_tx: default build (42-byte header, IFG=2)
// plus a HDR_LEN=0 / IFG=0 build.
module tb_trade_report_tx;
  import trade_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] in_data_a = 32'd0, in_data_b = 32'd0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic [7:0]  tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b;
  logic        tready_a = 1'b0, tready_b = 1'b0;
  logic        tlast_a, tlast_b;
  logic [15:0] seq_a, seq_b;
  logic        busy_a, busy_b;

  int          n_vec = 0;
  int          n_err = 0;

  logic [7:0]  cap_data[$];
  bit          cap_last[$];
  int          cap_cyc[$];
  int          acc_cyc[$];
  int          cap_busy_gap, cap_unstable, cap_ready_busy;
  bit          cap_timeout;
  logic [31:0] trades_q[$];
  logic [7:0]  exp_q[$];

  always #4 clk = ~clk;

  trade_report_tx dut_a (
    .clk_udp(clk), .rst_udp(rst),
    .trade_in(in_data_a), .trade_in_valid(in_valid_a), .trade_in_ready(in_ready_a),
    .tx_axis_tdata(tdata_a), .tx_axis_tvalid(tvalid_a), .tx_axis_tready(tready_a),
    .tx_axis_tlast(tlast_a), .tx_seq(seq_a), .tx_busy(busy_a)
  );

  trade_report_tx #(.HDR_LEN(0), .HDR_FILL(8'hAA), .IFG(0)) dut_b (
    .clk_udp(clk), .rst_udp(rst),
    .trade_in(in_data_b), .trade_in_valid(in_valid_b), .trade_in_ready(in_ready_b),
    .tx_axis_tdata(tdata_b), .tx_axis_tvalid(tvalid_b), .tx_axis_tready(tready_b),
    .tx_axis_tlast(tlast_b), .tx_seq(seq_b), .tx_busy(busy_b)
  );

  // Appends the expected packet bytes (header, seq, payload) to exp_q.
  task automatic build_exp(input int hdr, input logic [15:0] s, input logic [31:0] w);
    for (int i = 0; i < hdr; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Feeds trades_q as an FWFT FIFO and records handshaken bytes until npkts tlasts.
  task automatic capture(input int which, input int npkts, input int stall_pct);
    int          cyc, got;
    bit          pop_pend;
    logic        pv, pr, pl, v, l, busy, rdy, nr, iv;
    logic [7:0]  pd, d;
    logic [31:0] tmp;
    cyc = 0; got = 0; pop_pend = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    cap_data.delete(); cap_last.delete(); cap_cyc.delete(); acc_cyc.delete();
    cap_busy_gap = 0; cap_unstable = 0; cap_ready_busy = 0;
    while (got < npkts && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (pop_pend) begin
        tmp = trades_q.pop_front();
        pop_pend = 1'b0;
      end
      iv = (trades_q.size() != 0);
      if (which == 0) begin
        in_valid_a = iv;
        if (iv) in_data_a = trades_q[0];
        v = tvalid_a; d = tdata_a; l = tlast_a; busy = busy_a; rdy = in_ready_a;
      end else begin
        in_valid_b = iv;
        if (iv) in_data_b = trades_q[0];
        v = tvalid_b; d = tdata_b; l = tlast_b; busy = busy_b; rdy = in_ready_b;
      end
      if (iv && rdy) begin
        pop_pend = 1'b1;
        acc_cyc.push_back(cyc);
      end
      if (pv && !pr && (v !== 1'b1 || d !== pd || l !== pl)) cap_unstable++;
      if (busy && !v) cap_busy_gap++;
      if (busy && rdy) cap_ready_busy++;
      nr = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      if (which == 0) tready_a = nr;
      else tready_b = nr;
      if (v && nr) begin
        cap_data.push_back(d);
        cap_last.push_back(l);
        cap_cyc.push_back(cyc);
        if (l) got++;
      end
      pv = v; pr = nr; pd = d; pl = l;
    end
    cap_timeout = (got < npkts);
    @(posedge clk);
    #1;
    if (pop_pend) tmp = trades_q.pop_front();
    if (which == 0) in_valid_a = (trades_q.size() != 0);
    else in_valid_b = (trades_q.size() != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++; if (tvalid_a !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b exp 0", tvalid_a); end
    n_vec++; if (tdata_a !== 8'h00) begin n_err++; $display("FAIL rst_tdata got %02h exp 00", tdata_a); end
    n_vec++; if (tlast_a !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b exp 0", tlast_a); end
    n_vec++; if (seq_a !== 16'h0000) begin n_err++; $display("FAIL rst_seq got %04h exp 0000", seq_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy_a); end
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", in_ready_a); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b exp 1", in_ready_a); end
  endtask

  task automatic test_single();
    repeat (2) @(negedge clk);
    trades_q.push_back(trade_word(16'h0064, 1'b1, 1'b1, 14'h000A));
    exp_q.delete();
    build_exp(42, 16'h0000, 32'h0064C00A);
    capture(0, 1, 0);
    n_vec++; if (cap_timeout || cap_data.size() != 48) begin n_err++; $display("FAIL single_len got %0d exp 48", cap_data.size()); end
    for (int i = 0; i < 48; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) begin
        n_err++; $display("FAIL single_byte[%0d] got %02h exp %02h", i, (i < cap_data.size()) ? cap_data[i] : 8'h00, exp_q[i]);
      end
      n_vec++;
      if (i < cap_last.size() && cap_last[i] !== (i == 47)) begin
        n_err++; $display("FAIL single_tlast[%0d] got %b exp %b", i, cap_last[i], (i == 47));
      end
    end
    @(negedge clk);
    n_vec++; if (seq_a !== 16'h0001) begin n_err++; $display("FAIL single_seq got %04h exp 0001", seq_a); end
  endtask

  task automatic test_back_to_back();
    int t1;
    repeat (6) @(negedge clk);
    trades_q.push_back(32'h12348005);
    trades_q.push_back(32'hFFFF3FFF);
    exp_q.delete();
    build_exp(42, 16'h0001, 32'h12348005);
    build_exp(42, 16'h0002, 32'hFFFF3FFF);
    capture(0, 2, 0);
    n_vec++; if (cap_timeout || cap_data.size() != 96) begin n_err++; $display("FAIL b2b_len got %0d exp 96", cap_data.size()); end
    for (int i = 0; i < 96; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i == 47 || i == 95)) begin
        n_err++; $display("FAIL b2b_byte[%0d] got %02h exp %02h", i, (i < cap_data.size()) ? cap_data[i] : 8'h00, exp_q[i]);
      end
    end
    if (cap_cyc.size() == 96 && acc_cyc.size() == 2) begin
      t1 = cap_cyc[47];
      n_vec++; if (acc_cyc[1] - t1 != 3) begin n_err++; $display("FAIL b2b_accept_gap got %0d exp 3", acc_cyc[1] - t1); end
      n_vec++; if (cap_cyc[48] - t1 != 4) begin n_err++; $display("FAIL b2b_first_byte got %0d exp 4", cap_cyc[48] - t1); end
    end else begin
      n_vec++; n_err++; $display("FAIL b2b_timing got %0d accepts exp 2", acc_cyc.size());
    end
    n_vec++; if (cap_busy_gap != 2) begin n_err++; $display("FAIL b2b_ifg got %0d exp 2", cap_busy_gap); end
    @(negedge clk);
    n_vec++; if (seq_a !== 16'h0003) begin n_err++; $display("FAIL b2b_seq got %04h exp 0003", seq_a); end
  endtask

  task automatic test_stall();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    trades_q.push_back(32'h0064C00A);
    exp_q.delete();
    build_exp(42, 16'h0000, 32'h0064C00A);
    capture(0, 1, 50);
    n_vec++; if (cap_timeout || cap_data.size() != 48) begin n_err++; $display("FAIL stall_len got %0d exp 48", cap_data.size()); end
    for (int i = 0; i < 48; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i == 47)) begin
        n_err++; $display("FAIL stall_byte[%0d] got %02h exp %02h", i, (i < cap_data.size()) ? cap_data[i] : 8'h00, exp_q[i]);
      end
    end
    n_vec++; if (cap_unstable != 0) begin n_err++; $display("FAIL stall_hold got %0d changes exp 0", cap_unstable); end
    n_vec++; if (cap_ready_busy != 0) begin n_err++; $display("FAIL stall_ready got %0d busy-ready cycles exp 0", cap_ready_busy); end
    @(negedge clk);
    n_vec++; if (seq_a !== 16'h0001) begin n_err++; $display("FAIL stall_seq got %04h exp 0001", seq_a); end
  endtask

  task automatic test_reset_mid();
    int  cnt, cyc;
    bit  saw_last;
    repeat (6) @(negedge clk);
    in_data_a = 32'h0BADF00D; in_valid_a = 1'b1; tready_a = 1'b1;
    cnt = 0; cyc = 0; saw_last = 1'b0;
    while (cnt < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy_a) in_valid_a = 1'b0;
      if (tvalid_a) begin
        if (tlast_a) saw_last = 1'b1;
        cnt++;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (cnt != 20) begin n_err++; $display("FAIL mid_reach got %0d bytes exp 20", cnt); end
    n_vec++; if (tvalid_a !== 1'b0) begin n_err++; $display("FAIL mid_tvalid got %b exp 0", tvalid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", busy_a); end
    n_vec++; if (tlast_a !== 1'b0 || saw_last) begin n_err++; $display("FAIL mid_tlast got %b exp 0", tlast_a | saw_last); end
    n_vec++; if (tdata_a !== 8'h00) begin n_err++; $display("FAIL mid_tdata got %02h exp 00", tdata_a); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    trades_q.push_back(32'h00010001);
    exp_q.delete();
    build_exp(42, 16'h0000, 32'h00010001);
    capture(0, 1, 0);
    n_vec++; if (cap_timeout || cap_data.size() != 48) begin n_err++; $display("FAIL mid_len got %0d exp 48", cap_data.size()); end
    for (int i = 0; i < 48; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) begin
        n_err++; $display("FAIL mid_byte[%0d] got %02h exp %02h", i, (i < cap_data.size()) ? cap_data[i] : 8'h00, exp_q[i]);
      end
    end
  endtask

  task automatic test_seq_wrap();
    repeat (6) @(negedge clk);
    force dut_a.r_tx_seq = 16'hFFFF;
    #1;
    release dut_a.r_tx_seq;
    @(negedge clk);
    n_vec++; if (seq_a !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %04h exp FFFF", seq_a); end
    trades_q.push_back(32'h7FFF4001);
    exp_q.delete();
    build_exp(42, 16'hFFFF, 32'h7FFF4001);
    capture(0, 1, 0);
    n_vec++; if (cap_timeout || cap_data.size() != 48) begin n_err++; $display("FAIL wrap_len got %0d exp 48", cap_data.size()); end
    for (int i = 40; i < 48; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) begin
        n_err++; $display("FAIL wrap_byte[%0d] got %02h exp %02h", i, (i < cap_data.size()) ? cap_data[i] : 8'h00, exp_q[i]);
      end
    end
    @(negedge clk);
    n_vec++; if (seq_a !== 16'h0000) begin n_err++; $display("FAIL wrap_seq got %04h exp 0000", seq_a); end
  endtask

  task automatic test_no_hdr();
    int t1;
    repeat (2) @(negedge clk);
    trades_q.push_back(32'hA5A5C3C3);
    trades_q.push_back(32'h00000001);
    exp_q.delete();
    build_exp(0, 16'h0000, 32'hA5A5C3C3);
    build_exp(0, 16'h0001, 32'h00000001);
    capture(1, 2, 0);
    n_vec++; if (cap_timeout || cap_data.size() != 12) begin n_err++; $display("FAIL nohdr_len got %0d exp 12", cap_data.size()); end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i == 5 || i == 11)) begin
        n_err++; $display("FAIL nohdr_byte[%0d] got %02h exp %02h", i, (i < cap_data.size()) ? cap_data[i] : 8'h00, exp_q[i]);
      end
    end
    if (cap_cyc.size() == 12 && acc_cyc.size() == 2) begin
      t1 = cap_cyc[5];
      n_vec++; if (acc_cyc[1] - t1 != 1) begin n_err++; $display("FAIL nohdr_accept_gap got %0d exp 1", acc_cyc[1] - t1); end
      n_vec++; if (cap_cyc[6] - t1 != 2) begin n_err++; $display("FAIL nohdr_first_byte got %0d exp 2", cap_cyc[6] - t1); end
    end else begin
      n_vec++; n_err++; $display("FAIL nohdr_timing got %0d accepts exp 2", acc_cyc.size());
    end
    n_vec++; if (cap_busy_gap != 0) begin n_err++; $display("FAIL nohdr_ifg got %0d exp 0", cap_busy_gap); end
    @(negedge clk);
    n_vec++; if (seq_b !== 16'h0002) begin n_err++; $display("FAIL nohdr_seq got %04h exp 0002", seq_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_seq_wrap();
    test_no_hdr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
